// File: rtl/t_flipflop_array.sv
// t_flipflop_array: bank of WIDTH T flip-flops clocked on the falling edge of clk.
// The bank runs as independent per-bit toggles (mode 00), as a chained T-FF up
// counter (01) or down counter (10), or holds (11). It also provides parallel
// load, terminal count and a one-cycle wrap pulse.
// Optional feature macro: T_FLIPFLOP_ARRAY_OVF_EN enables the sticky overflow
// flag. When the macro is undefined, ovf is tied low and ovf_clr is ignored.
module t_flipflop_array #(
    parameter int unsigned           WIDTH       = 8,
    parameter logic [WIDTH-1:0]      RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  t,
    input  logic              load,
    input  logic [WIDTH-1:0]  d,
    input  logic              ovf_clr,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  qbar,
    output logic              tc,
    output logic              wrap,
    output logic              ovf
);

    localparam logic [1:0] MODE_TOGGLE = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DOWN   = 2'b10;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             tc_s;
    logic [WIDTH-1:0] tog_s;

    // Ripple enables of the T-FF chain: bit i toggles once every lower bit is 1
    // (counting up) or once every lower bit is 0 (counting down).
    logic [WIDTH:0]   up_chain_s;
    logic [WIDTH:0]   dn_chain_s;

    assign up_chain_s[0] = 1'b1;
    assign dn_chain_s[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chain
            assign up_chain_s[gi+1] = up_chain_s[gi] &  q_q[gi];
            assign dn_chain_s[gi+1] = dn_chain_s[gi] & ~q_q[gi];
        end
    endgenerate

    // The terminal count matches the wrap condition: the end of a full chain
    // means that every bit toggles on the next count.
    assign tc_s = en & (((mode == MODE_UP)   & up_chain_s[WIDTH]) |
                        ((mode == MODE_DOWN) & dn_chain_s[WIDTH]));

    // Select the per-bit toggle vector for the current mode.
    always_comb begin
        tog_s = {WIDTH{1'b0}};
        case (mode)
            MODE_TOGGLE: tog_s = t;
            MODE_UP:     tog_s = up_chain_s[WIDTH-1:0];
            MODE_DOWN:   tog_s = dn_chain_s[WIDTH-1:0];
            default:     tog_s = {WIDTH{1'b0}};
        endcase
    end

    // Next state for q and wrap. Load beats counting, and a load cancels any wrap.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (load) begin
            q_d    = d;
            wrap_d = 1'b0;
        end else if (en) begin
            q_d    = q_q ^ tog_s;
            wrap_d = tc_s;
        end else begin
            q_d    = q_q;
            wrap_d = 1'b0;
        end
    end

    // State register on the falling edge, with synchronous reset taking priority.
    always_ff @(negedge clk) begin
        if (rst) begin
            q_q    <= RESET_VALUE;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

`ifdef T_FLIPFLOP_ARRAY_OVF_EN
    logic ovf_q;
    logic ovf_d;

    // Sticky overflow: a load freezes it; otherwise a wrap event sets it (and
    // beats a simultaneous clear), and ovf_clr clears it.
    always_comb begin
        ovf_d = ovf_q;
        if (load) begin
            ovf_d = ovf_q;
        end else if (tc_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Overflow register, cleared by synchronous reset.
    always_ff @(negedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf_clr_s;
    assign unused_ovf_clr_s = ovf_clr;
    assign ovf = 1'b0;
`endif

    assign q    = q_q;
    assign qbar = ~q_q;
    assign tc   = tc_s;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_t_flipflop_array.sv
// Testbench for t_flipflop_array with WIDTH=4 and RESET_VALUE=4'h5. A
// behavioural reference model pushes the expected state into a scoreboard
// whenever stimulus is driven. The bench pops and compares that state after the
// falling edge that consumes the stimulus.
module tb_t_flipflop_array;

    localparam int unsigned W  = 4;
    localparam logic [W-1:0] RV = 4'h5;
`ifdef T_FLIPFLOP_ARRAY_OVF_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'b11;
    logic [W-1:0] t = 4'h0;
    logic         load = 1'b0;
    logic [W-1:0] d = 4'h0;
    logic         ovf_clr = 1'b0;
    logic [W-1:0] q;
    logic [W-1:0] qbar;
    logic         tc;
    logic         wrap;
    logic         ovf;

    t_flipflop_array #(.WIDTH(W), .RESET_VALUE(RV)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .load(load),
        .d(d), .ovf_clr(ovf_clr), .q(q), .qbar(qbar), .tc(tc),
        .wrap(wrap), .ovf(ovf)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] q;
        logic         wrap;
        logic         ovf;
    } exp_t;

    exp_t         sb_q[$];
    int           n_chk  = 0;
    int           n_pass = 0;
    logic [W-1:0] mq     = 4'h0;
    logic         mwrap  = 1'b0;
    logic         movf   = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    // Drive one cycle of stimulus and check tc before the edge. Update the
    // model and push the expected state, then pop and compare after the edge.
    task automatic drive(input logic r, input logic ld, input logic e, input logic [1:0] m,
                         input logic [W-1:0] tt, input logic [W-1:0] dd, input logic clr);
        logic mtc;
        exp_t e_v;
        @(posedge clk);
        rst = r; load = ld; en = e; mode = m; t = tt; d = dd; ovf_clr = clr;
        #1;
        mtc = e & (((m == 2'b01) && (mq == 4'hF)) || ((m == 2'b10) && (mq == 4'h0)));
        check_val("tc", {31'd0, tc}, {31'd0, mtc});
        if (r) begin
            mq = RV; mwrap = 1'b0; movf = 1'b0;
        end else if (ld) begin
            mq = dd; mwrap = 1'b0;
        end else begin
            mwrap = mtc;
            if (OVF_EN && mtc) movf = 1'b1;
            else if (OVF_EN && clr) movf = 1'b0;
            if (e && m == 2'b00) mq = mq ^ tt;
            else if (e && m == 2'b01) mq = mq + 4'h1;
            else if (e && m == 2'b10) mq = mq - 4'h1;
        end
        e_v.q = mq; e_v.wrap = mwrap; e_v.ovf = movf;
        sb_q.push_back(e_v);
        @(negedge clk);
        #2;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
        end else begin
            e_v = sb_q.pop_front();
            check_val("q",    {28'd0, q},    {28'd0, e_v.q});
            check_val("qbar", {28'd0, qbar}, {28'd0, ~e_v.q});
            check_val("wrap", {31'd0, wrap}, {31'd0, e_v.wrap});
            check_val("ovf",  {31'd0, ovf},  {31'd0, e_v.ovf});
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    // Directed test-plan sequence followed by random stimulus.
    initial begin
        // Reset
        drive(1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
        check_val("tp_rst_q", {28'd0, q}, 32'h5);
        check_val("tp_rst_qbar", {28'd0, qbar}, 32'hA);
        // Independent toggle
        drive(1'b0, 1'b1, 1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 2'b00, 4'hA, 4'h0, 1'b0);
        check_val("tp_tog1", {28'd0, q}, 32'hA);
        drive(1'b0, 1'b0, 1'b1, 2'b00, 4'hA, 4'h0, 1'b0);
        check_val("tp_tog2", {28'd0, q}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 2'b00, 4'hA, 4'h0, 1'b0);
        check_val("tp_en0", {28'd0, q}, 32'h0);
        // Count up through the wrap
        drive(1'b0, 1'b1, 1'b1, 2'b01, 4'h0, 4'hE, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 2'b01, 4'h0, 4'h0, 1'b0);
        check_val("tp_up_f", {28'd0, q}, 32'hF);
        drive(1'b0, 1'b0, 1'b1, 2'b01, 4'h0, 4'h0, 1'b0);
        check_val("tp_up_wrap", {31'd0, wrap}, 32'd1);
        check_val("tp_up_ovf", {31'd0, ovf}, {31'd0, OVF_EN});
        drive(1'b0, 1'b0, 1'b1, 2'b01, 4'h0, 4'h0, 1'b0);
        check_val("tp_up_wrap_end", {31'd0, wrap}, 32'd0);
        // Count down through the wrap, then clear ovf
        drive(1'b0, 1'b1, 1'b1, 2'b10, 4'h0, 4'h1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 2'b10, 4'h0, 4'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 2'b10, 4'h0, 4'h0, 1'b0);
        check_val("tp_dn_wrap", {31'd0, wrap}, 32'd1);
        check_val("tp_dn_q", {28'd0, q}, 32'hF);
        drive(1'b0, 1'b0, 1'b0, 2'b10, 4'h0, 4'h0, 1'b1);
        check_val("tp_ovf_clr", {31'd0, ovf}, 32'd0);
        // Load beats a would-be wrap; reset beats load
        drive(1'b0, 1'b1, 1'b1, 2'b01, 4'h0, 4'hF, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 2'b01, 4'h0, 4'h3, 1'b0);
        check_val("tp_ld_wrap", {31'd0, wrap}, 32'd0);
        check_val("tp_ld_q", {28'd0, q}, 32'h3);
        drive(1'b1, 1'b1, 1'b1, 2'b01, 4'h0, 4'h9, 1'b0);
        check_val("tp_rst_ld", {28'd0, q}, 32'h5);
        // A wrap set beats ovf_clr on the same edge
        drive(1'b0, 1'b1, 1'b1, 2'b01, 4'h0, 4'hF, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 2'b01, 4'h0, 4'h0, 1'b1);
        check_val("tp_set_clr", {31'd0, ovf}, {31'd0, OVF_EN});
        // Hold mode
        drive(1'b0, 1'b0, 1'b1, 2'b11, 4'hF, 4'h0, 1'b0);
        check_val("tp_hold", {28'd0, q}, 32'h0);
        // Random stimulus
        for (int i = 0; i < 200; i++) begin
            drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 5) == 0));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
